ram_mem_responder: RTL and testbench

Memory-side responder for the load/store datapath. It serves one byte-addressed read or write at a time from an internal 64-bit-word SRAM over a valid/ready request channel and a valid/ready response channel, with a fixed access latency. It performs byte-lane steering for write data and offset extraction for read data. Sign/zero extension stays with the initiator.

---
 rtl/ram_mem_responder.sv | 133 +++++++++++++
 tb/tb_ram_mem_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_mem_responder.sv
// Single-outstanding SRAM responder: valid/ready request in, fixed-latency response out,
// byte-lane steering on writes and offset extraction on reads.
module ram_mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    // state | meaning
    // IDLE  | ready for a request
    // BUSY  | latency countdown, request fields held in l_*
    // RESP  | response presented until resp_ready
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;

    logic          l_we;
    logic [63:0]   l_addr;
    logic [1:0]    l_size;
    logic [63:0]   l_wdata;

    logic [63:0]   mem [DEPTH];

    logic          c_we;
    logic [63:0]   c_addr;
    logic [1:0]    c_size;
    logic [63:0]   c_wdata;
    logic [60:0]   rel_word;
    logic [2:0]    off;
    logic [AW-1:0] idx;
    logic          err_oob, err_mis, err;
    logic [7:0]    size_bytes, byte_mask;
    logic [63:0]   wdata_sh, rdata_sh, wmask;
    logic          accept, enter_resp;

    function automatic logic [63:0] expand(input logic [7:0] m);
        expand = '0;
        for (int i = 0; i < 8; i++) expand[8*i +: 8] = {8{m[i]}};
    endfunction

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign enter_resp = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == CW'(1)));

    // With LATENCY==1 the commit edge is the accept edge, so decode the live request in IDLE.
    assign c_we    = (state == IDLE) ? req_we    : l_we;
    assign c_addr  = (state == IDLE) ? req_addr  : l_addr;
    assign c_size  = (state == IDLE) ? req_size  : l_size;
    assign c_wdata = (state == IDLE) ? req_wdata : l_wdata;

    assign off      = c_addr[2:0];
    assign rel_word = c_addr[63:3] - BASE_ADDR[63:3];
    assign idx      = rel_word[AW-1:0];
    assign err_oob  = (c_addr < BASE_ADDR) || (rel_word >= 61'(DEPTH));

    always_comb begin
        size_bytes = 8'h01;
        err_mis    = 1'b0;
        case (c_size)
            2'd0: begin size_bytes = 8'h01; err_mis = 1'b0;          end
            2'd1: begin size_bytes = 8'h03; err_mis = c_addr[0];     end
            2'd2: begin size_bytes = 8'h0F; err_mis = |c_addr[1:0];  end
            default: begin size_bytes = 8'hFF; err_mis = |c_addr[2:0]; end
        endcase
    end

    assign err       = err_oob || err_mis;
    assign byte_mask = size_bytes << off;
    assign wmask     = expand(byte_mask);
    assign wdata_sh  = c_wdata << {off, 3'b000};
    assign rdata_sh  = mem[idx] >> {off, 3'b000};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (LATENCY == 1) ? RESP : BUSY;
            BUSY:    if (cnt == CW'(1)) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                l_we    <= req_we;
                l_addr  <= req_addr;
                l_size  <= req_size;
                l_wdata <= req_wdata;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
            end
            if (enter_resp) begin
                resp_err   <= err;
                resp_rdata <= (err || c_we) ? 64'd0 : (rdata_sh & expand(size_bytes));
            end
        end
    end

    // Array is never reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && c_we && !err)
            mem[idx] <= (mem[idx] & ~wmask) | (wdata_sh & wmask);
    end
endmodule

// File: tb/tb_ram_mem_responder.sv
// Bench for ram_mem_responder: LATENCY 2/1/4 instances against a byte-level reference model,
// with directed scenarios and randomized traffic.
module tb_ram_mem_responder;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rv[3], we_i[3], rr[3];
    logic [63:0] addr_i[3], wd_i[3];
    logic [1:0]  sz_i[3];
    logic        rq_rdy[3], rs_v[3], rs_e[3];
    logic [63:0] rs_d[3];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;
    int lat_of[3] = '{2, 1, 4};

    ram_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rq_rdy[0]), .req_we(we_i[0]),
        .req_addr(addr_i[0]), .req_size(sz_i[0]), .req_wdata(wd_i[0]), .resp_valid(rs_v[0]),
        .resp_ready(rr[0]), .resp_rdata(rs_d[0]), .resp_err(rs_e[0]));
    ram_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rq_rdy[1]), .req_we(we_i[1]),
        .req_addr(addr_i[1]), .req_size(sz_i[1]), .req_wdata(wd_i[1]), .resp_valid(rs_v[1]),
        .resp_ready(rr[1]), .resp_rdata(rs_d[1]), .resp_err(rs_e[1]));
    ram_mem_responder #(.DEPTH(DEPTH), .LATENCY(4), .BASE_ADDR(BASE)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rq_rdy[2]), .req_we(we_i[2]),
        .req_addr(addr_i[2]), .req_size(sz_i[2]), .req_wdata(wd_i[2]), .resp_valid(rs_v[2]),
        .resp_ready(rr[2]), .resp_rdata(rs_d[2]), .resp_err(rs_e[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_to(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out, event never seen (cycle %0d)", nm, cyc);
    endtask

    // Reference model: one pending transaction per instance, memory as bytes relative to BASE.
    logic [7:0]  mm[3][256];
    bit          busy[3], started[3], m_we[3];
    int          due[3];
    logic [63:0] m_addr[3], m_wd[3], e_d[3];
    logic [1:0]  m_sz[3];
    logic        e_e[3];

    task automatic model_exec(input int k);
        logic [63:0] a;
        int nb, o;
        bit oob, mis;
        a      = m_addr[k];
        nb     = 1 << m_sz[k];
        oob    = (a < BASE) || (((a - BASE) >> 3) >= 64'(DEPTH));
        mis    = (a % 64'(nb)) != 0;
        e_d[k] = '0;
        e_e[k] = oob || mis;
        if (!e_e[k]) begin
            o = int'(a - BASE);
            for (int i = 0; i < nb; i++) begin
                if (m_we[k]) mm[k][o+i] = m_wd[k][8*i +: 8];
                else e_d[k][8*i +: 8] = mm[k][o+i];
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            busy[k] = 0; started[k] = 0; due[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int k = 0; k < 3; k++) begin
                    bit erdy, evld;
                    erdy = !busy[k];
                    evld = busy[k] && (cyc >= due[k]);
                    if (evld && !started[k]) begin
                        model_exec(k);
                        started[k] = 1;
                    end
                    chk($sformatf("req_ready[%0d]", k), rq_rdy[k], erdy);
                    chk($sformatf("resp_valid[%0d]", k), rs_v[k], evld);
                    if (evld) begin
                        chk($sformatf("resp_rdata[%0d]", k), rs_d[k], e_d[k]);
                        chk($sformatf("resp_err[%0d]", k), rs_e[k], e_e[k]);
                    end
                    if (rst) busy[k] = 0;
                    else if (evld && rr[k]) busy[k] = 0;
                    else if (!busy[k] && rv[k]) begin
                        busy[k]    = 1;
                        started[k] = 0;
                        due[k]     = cyc + lat_of[k];
                        m_we[k]    = we_i[k];
                        m_addr[k]  = addr_i[k];
                        m_sz[k]    = sz_i[k];
                        m_wd[k]    = wd_i[k];
                    end
                end
            end
        end
    end

    task automatic pick(output logic w, output logic [63:0] a, output logic [1:0] s,
                        output logic [63:0] d);
        int o, sel;
        w   = 1'($urandom_range(0, 1));
        s   = 2'($urandom_range(0, 3));
        d   = {$urandom, $urandom};
        o   = $urandom_range(0, 127);
        if ($urandom_range(0, 3) != 0) o = o & ~((1 << s) - 1);
        sel = $urandom_range(0, 9);
        if (sel == 0) a = BASE - 64'(1 + $urandom_range(0, 255));
        else if (sel == 1) a = BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 255));
        else a = BASE + 64'(o);
    endtask

    task automatic do_req(input int k, input logic w, input logic [63:0] a, input logic [1:0] s,
                          input logic [63:0] d, input int stall_pct,
                          output logic [63:0] rd, output logic er, output int lat);
        bit ok;
        int acc_c;
        rd = '0; er = 1'b0; lat = -1; ok = 0;
        @(posedge clk); #1;
        rv[k] = 1; we_i[k] = w; addr_i[k] = a; sz_i[k] = s; wd_i[k] = d; rr[k] = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (rq_rdy[k]) begin ok = 1; break; end
        end
        if (!ok) begin
            fail_to("accept");
            @(posedge clk); #1 rv[k] = 0;
            return;
        end
        acc_c = cyc;
        @(posedge clk); #1;
        rv[k] = 0;
        rr[k] = ($urandom_range(0, 99) >= stall_pct);
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rs_v[k] && lat < 0) lat = cyc - acc_c;
            if (rs_v[k] && rr[k]) begin
                rd = rs_d[k]; er = rs_e[k]; ok = 1;
                break;
            end
            @(posedge clk); #1 rr[k] = ($urandom_range(0, 99) >= stall_pct);
        end
        if (!ok) fail_to("response");
        @(posedge clk); #1 rr[k] = 0;
    endtask

    task automatic wait_resp(input int k, output logic [63:0] rd, output logic er);
        bit ok;
        ok = 0; rd = '0; er = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rs_v[k] && rr[k]) begin rd = rs_d[k]; er = rs_e[k]; ok = 1; break; end
        end
        if (!ok) fail_to("wait_resp");
        @(posedge clk); #1 rr[k] = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd, cap_d, a, d;
        logic        er, cap_e, w;
        logic [1:0]  s;
        int          lat, last_acc, n_acc;
        bit          ok;

        for (int k = 0; k < 3; k++) begin
            rv[k] = 0; we_i[k] = 0; rr[k] = 0; addr_i[k] = '0; wd_i[k] = '0; sz_i[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_on = 1;
        @(negedge clk);
        chk("rst resp_valid", rs_v[0], 1'b0);
        chk("rst resp_rdata", rs_d[0], 64'd0);
        chk("rst resp_err", rs_e[0], 1'b0);
        chk("rst req_ready", rq_rdy[0], 1'b1);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) begin
                do_req(k, 1, BASE + 64'(8 * i), 2'd3, {$urandom, $urandom}, 0, rd, er, lat);
                chk("init err", er, 1'b0);
            end

        // Directed scenarios on the LATENCY=2 instance
        do_req(0, 1, 64'h8000_0008, 2'd3, 64'h1122334455667788, 0, rd, er, lat);
        chk("t1 write err", er, 1'b0);
        chk("t1 write latency", 64'(lat), 64'd2);
        chk("t1 write rdata", rd, 64'd0);
        do_req(0, 0, 64'h8000_0008, 2'd3, 64'd0, 0, rd, er, lat);
        chk("t1 read", rd, 64'h1122334455667788);
        chk("t1 read latency", 64'(lat), 64'd2);

        do_req(0, 1, 64'h8000_000B, 2'd0, 64'h0000_0000_0000_00AA, 0, rd, er, lat);
        do_req(0, 0, 64'h8000_0008, 2'd3, 64'd0, 0, rd, er, lat);
        chk("t2 read dword", rd, 64'h11223344AA667788);
        do_req(0, 0, 64'h8000_000A, 2'd1, 64'd0, 0, rd, er, lat);
        chk("t2 read half", rd, 64'h0000_0000_0000_AA66);

        do_req(0, 1, 64'h8000_0000, 2'd3, 64'h0123456789ABCDEF, 0, rd, er, lat);
        do_req(0, 0, 64'h8000_0006, 2'd2, 64'd0, 0, rd, er, lat);
        chk("t3 misaligned err", er, 1'b1);
        chk("t3 misaligned rdata", rd, 64'd0);
        do_req(0, 1, 64'h7FFF_FFF8, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, er, lat);
        chk("t3 below-base err", er, 1'b1);
        chk("t3 below-base rdata", rd, 64'd0);
        do_req(0, 0, 64'h8000_0000, 2'd3, 64'd0, 0, rd, er, lat);
        chk("t3 unchanged", rd, 64'h0123456789ABCDEF);
        chk("t3 unchanged err", er, 1'b0);

        // Stall in RESP with a second request already pending
        @(posedge clk); #1;
        rv[0] = 1; we_i[0] = 0; addr_i[0] = 64'h8000_0008; sz_i[0] = 2'd3; rr[0] = 0;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (rq_rdy[0]) begin ok = 1; break; end
        end
        if (!ok) fail_to("t4 accept");
        @(posedge clk); #1;
        we_i[0] = 1; addr_i[0] = 64'h8000_0020; sz_i[0] = 2'd0; wd_i[0] = 64'h77;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rs_v[0]) begin ok = 1; break; end
        end
        if (!ok) fail_to("t4 resp_valid");
        cap_d = rs_d[0];
        cap_e = rs_e[0];
        chk("t4 stalled rdata", cap_d, 64'h11223344AA667788);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4 hold valid", rs_v[0], 1'b1);
            chk("t4 hold rdata", rs_d[0], cap_d);
            chk("t4 hold err", rs_e[0], cap_e);
            chk("t4 hold req_ready", rq_rdy[0], 1'b0);
        end
        @(posedge clk); #1 rr[0] = 1;
        @(negedge clk);
        chk("t4 handshake valid", rs_v[0], 1'b1);
        chk("t4 no same-cycle accept", rq_rdy[0], 1'b0);
        @(posedge clk); #1 rr[0] = 0;
        @(negedge clk);
        chk("t4 pending accepted", rq_rdy[0], 1'b1);
        @(posedge clk); #1 rv[0] = 0; rr[0] = 1;
        wait_resp(0, rd, er);
        chk("t4 pending write err", er, 1'b0);
        do_req(0, 0, 64'h8000_0020, 2'd0, 64'd0, 0, rd, er, lat);
        chk("t4 pending write data", rd, 64'h77);

        // Reset during BUSY aborts the write
        do_req(0, 1, 64'h8000_0010, 2'd3, 64'h5A5A5A5A5A5A5A5A, 0, rd, er, lat);
        @(posedge clk); #1;
        rv[0] = 1; we_i[0] = 1; addr_i[0] = 64'h8000_0010; sz_i[0] = 2'd3;
        wd_i[0] = 64'hFFFF_FFFF_FFFF_FFFF; rr[0] = 1;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (rq_rdy[0]) begin ok = 1; break; end
        end
        if (!ok) fail_to("t5 accept");
        @(posedge clk); #1 rv[0] = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("t5 resp_valid", rs_v[0], 1'b0);
        chk("t5 resp_rdata", rs_d[0], 64'd0);
        chk("t5 resp_err", rs_e[0], 1'b0);
        chk("t5 req_ready", rq_rdy[0], 1'b1);
        rr[0] = 0;
        do_req(0, 0, 64'h8000_0010, 2'd3, 64'd0, 0, rd, er, lat);
        chk("t5 prior content", rd, 64'h5A5A5A5A5A5A5A5A);

        // Back-to-back traffic on the LATENCY=1 and LATENCY=4 instances
        for (int k = 1; k < 3; k++) begin
            @(posedge clk); #1;
            pick(w, a, s, d);
            rv[k] = 1; we_i[k] = w; addr_i[k] = a; sz_i[k] = s; wd_i[k] = d; rr[k] = 1;
            last_acc = -1; n_acc = 0;
            for (int t = 0; t < 300 && n_acc < 12; t++) begin
                @(negedge clk);
                if (rs_v[k] && last_acc >= 0)
                    chk($sformatf("t6 latency[%0d]", k), 64'(cyc - last_acc), 64'(lat_of[k]));
                if (rq_rdy[k]) begin
                    if (last_acc >= 0)
                        chk($sformatf("t6 period[%0d]", k), 64'(cyc - last_acc), 64'(lat_of[k] + 1));
                    last_acc = cyc;
                    n_acc++;
                    @(posedge clk); #1;
                    if (n_acc < 12) begin
                        pick(w, a, s, d);
                        we_i[k] = w; addr_i[k] = a; sz_i[k] = s; wd_i[k] = d;
                    end else rv[k] = 0;
                end
            end
            if (n_acc < 12) fail_to("t6 accepts");
            rv[k] = 0;
            repeat (lat_of[k] + 3) @(posedge clk);
            #1 rr[k] = 0;
        end

        // Randomized traffic with random response back-pressure
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 60; i++) begin
                pick(w, a, s, d);
                do_req(k, w, a, s, d, 30, rd, er, lat);
            end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
